// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// bram_pkg: shared constants and helpers for the single-port byte-enable BRAM.
// Rev 1.0
// ============================================================================
package bram_pkg;

    localparam string MODE_READ_FIRST  = "READ_FIRST";
    localparam string MODE_WRITE_FIRST = "WRITE_FIRST";
    localparam string MODE_NO_CHANGE   = "NO_CHANGE";

    // Upper bounds for the width-generic parity helper.
    localparam int PAR_MAX_W   = 1024;
    localparam int PAR_MAX_COL = 128;

    // Bits needed to represent value; never less than one so a depth-1 RAM
    // still has a legal address port.
    function automatic int clogb2(input int value);
        int v;
        int bits;
        v    = value;
        bits = 0;
        while (v > 0) begin
            bits++;
            v = v >> 1;
        end
        return (bits < 1) ? 1 : bits;
    endfunction

    function automatic logic [PAR_MAX_COL-1:0] lane_parity(
        input logic [PAR_MAX_W-1:0] data,
        input int                   ncol,
        input int                   cw
    );
        logic [PAR_MAX_COL-1:0] p;
        p = '0;
        for (int i = 0; i < ncol; i++) begin
            for (int b = 0; b < cw; b++) begin
                p[i] = p[i] ^ data[i*cw + b];
            end
        end
        return p;
    endfunction

    function automatic bit params_legal(
        input int    read_latency,
        input string write_mode,
        input int    ram_width,
        input int    col_width
    );
        bit ok;
        ok = (read_latency >= 1) && (read_latency <= 3);
        ok = ok && ((write_mode == MODE_READ_FIRST) ||
                    (write_mode == MODE_WRITE_FIRST) ||
                    (write_mode == MODE_NO_CHANGE));
        ok = ok && (col_width > 0) && (ram_width > 0) && ((ram_width % col_width) == 0);
        ok = ok && (ram_width <= PAR_MAX_W) && ((ram_width / col_width) <= PAR_MAX_COL);
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_out_pipe.sv
`default_nettype none
// ============================================================================
// bram_out_pipe: data/valid/parity-flag shift register for read stages
// 2..READ_LATENCY, advancing only on ce. Rev 1.0
// ============================================================================
module bram_out_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    input  logic             p_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out,
    output logic             p_out
);

    generate
        if (STAGES == 0) begin : g_passthru
            logic w_unused_ok;
            assign w_unused_ok = &{1'b0, clk, rst, ce};
            assign d_out = d_in;
            assign v_out = v_in;
            assign p_out = p_in;
        end else begin : g_regs
            logic [WIDTH-1:0]  r_d [STAGES];
            logic [STAGES-1:0] r_v;
            logic [STAGES-1:0] r_p;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < STAGES; k++) r_d[k] <= '0;
                    r_v <= '0;
                    r_p <= '0;
                end else if (ce) begin
                    r_d[0] <= d_in;
                    r_v[0] <= v_in;
                    r_p[0] <= p_in;
                    for (int k = 1; k < STAGES; k++) begin
                        r_d[k] <= r_d[k-1];
                        r_v[k] <= r_v[k-1];
                        r_p[k] <= r_p[k-1];
                    end
                end
            end

            assign d_out = r_d[STAGES-1];
            assign v_out = r_v[STAGES-1];
            assign p_out = r_p[STAGES-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/xilinx_single_port_ram_be.sv
`default_nettype none
// ============================================================================
// xilinx_single_port_ram_be: single-port BRAM with byte-lane writes, selectable
// write mode and 1..3 cycle read latency. Option macro: BRAM_PARITY_EN. Rev 1.0
// ============================================================================
module xilinx_single_port_ram_be
    import bram_pkg::*;
#(
    parameter int    RAM_WIDTH    = 32,
    parameter int    COL_WIDTH    = 8,
    parameter int    RAM_DEPTH    = 1024,
    parameter int    READ_LATENCY = 2,
    parameter string WRITE_MODE   = "READ_FIRST",
    parameter string INIT_FILE    = "",
    localparam int   NB_COL       = RAM_WIDTH / COL_WIDTH,
    localparam int   ADDR_W       = clogb2(RAM_DEPTH - 1)
) (
    input  logic                 clka,
    input  logic                 rsta,
    input  logic                 ena,
    input  logic [NB_COL-1:0]    wea,
    input  logic [ADDR_W-1:0]    addra,
    input  logic [RAM_WIDTH-1:0] dina,
    input  logic                 regcea,
    output logic [RAM_WIDTH-1:0] douta,
    output logic                 douta_valid,
    output logic                 perra
);

    localparam bit              c_params_ok   = params_legal(READ_LATENCY, WRITE_MODE, RAM_WIDTH, COL_WIDTH);
    localparam bit              c_write_first = (WRITE_MODE == MODE_WRITE_FIRST);
    localparam bit              c_no_change   = (WRITE_MODE == MODE_NO_CHANGE);
    localparam logic [ADDR_W:0] c_depth       = (ADDR_W+1)'(RAM_DEPTH);

    generate
        if (!c_params_ok) begin : g_bad_params
            $error("xilinx_single_port_ram_be: illegal READ_LATENCY, WRITE_MODE or RAM_WIDTH/COL_WIDTH");
        end
    endgenerate

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

    logic                 w_in_range;
    logic                 w_rd;
    logic [RAM_WIDTH-1:0] w_old;
    logic [RAM_WIDTH-1:0] w_merged;
    logic [RAM_WIDTH-1:0] w_d1_next;
    logic                 w_perr_next;
    logic [RAM_WIDTH-1:0] r_d1;
    logic                 r_v1;
    logic                 r_p1;
    logic                 w_pipe_p;

    always_comb begin
        w_in_range = ({1'b0, addra} < c_depth);
        w_rd       = ena && ((wea == '0) || !c_no_change);
        w_old      = w_in_range ? mem[addra] : '0;
        w_merged   = w_old;
        for (int i = 0; i < NB_COL; i++) begin
            if (wea[i]) w_merged[i*COL_WIDTH +: COL_WIDTH] = dina[i*COL_WIDTH +: COL_WIDTH];
        end
        // Dropped out-of-range writes must not leak into a WRITE_FIRST read.
        if (!w_in_range) w_merged = '0;
        w_d1_next = c_write_first ? w_merged : w_old;
    end

`ifdef BRAM_PARITY_EN
    logic [NB_COL-1:0] par_mem [RAM_DEPTH];
    logic [NB_COL-1:0] w_par_old;
    logic [NB_COL-1:0] w_par_din;
    logic [NB_COL-1:0] w_par_sel;

    function automatic logic [NB_COL-1:0] word_parity(input logic [RAM_WIDTH-1:0] w);
        return NB_COL'(lane_parity(PAR_MAX_W'(w), NB_COL, COL_WIDTH));
    endfunction

    always_comb begin
        w_par_old   = w_in_range ? par_mem[addra] : '0;
        w_par_din   = word_parity(dina);
        w_par_sel   = c_write_first ? ((w_par_old & ~wea) | (w_par_din & wea)) : w_par_old;
        w_perr_next = w_in_range && (w_par_sel != word_parity(w_d1_next));
    end

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
        for (int i = 0; i < RAM_DEPTH; i++) par_mem[i] = word_parity(mem[i]);
    end

    always @(posedge clka or posedge rsta) begin
        if (!rsta && ena && w_in_range) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (wea[i]) begin
                    mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
                    par_mem[addra][i] <= w_par_din[i];
                end
            end
        end
    end
`else
    assign w_perr_next = 1'b0;

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
    end

    // Reset only blocks writes; stored words survive it.
    always @(posedge clka or posedge rsta) begin
        if (!rsta && ena && w_in_range) begin
            for (int i = 0; i < NB_COL; i++) begin
                if (wea[i]) mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
            end
        end
    end
`endif

    always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
            r_d1 <= '0;
            r_v1 <= 1'b0;
            r_p1 <= 1'b0;
        end else begin
            r_v1 <= w_rd;
            if (w_rd) begin
                r_d1 <= w_d1_next;
                r_p1 <= w_perr_next;
            end
        end
    end

    bram_out_pipe #(
        .WIDTH  (RAM_WIDTH),
        .STAGES (READ_LATENCY - 1)
    ) u_out_pipe (
        .clk   (clka),
        .rst   (rsta),
        .ce    (regcea),
        .d_in  (r_d1),
        .v_in  (r_v1),
        .p_in  (r_p1),
        .d_out (douta),
        .v_out (douta_valid),
        .p_out (w_pipe_p)
    );

    // Without parity storage the flag is constant zero, so perra stays low.
    assign perra = douta_valid & w_pipe_p;

endmodule
`default_nettype wire
